// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: on a tie the requester not granted last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic    req_fetch,
  input  logic    req_data,
  input  req_id_t last_grant,
  output logic    any_req,
  output req_id_t winner
);

  // Pick a winner; a lone requester always wins, a tie alternates on last_grant
  always_comb begin
    any_req = req_fetch | req_data;
    winner  = REQ_FETCH;
    if (req_fetch && req_data) begin
      winner = (last_grant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (req_data) begin
      winner = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between instruction fetch and load/store,
// one transaction at a time, with a fixed read latency and registered outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state_out
);

  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  arb_state_t       state;
  req_id_t          last_grant;
  req_id_t          owner;
  req_id_t          winner;
  logic             any_req;
  logic             lat_we;
  logic [CNT_W-1:0] wait_cnt;

  arb_rr2 u_rr (
    .req_fetch  (if_req),
    .req_data   (d_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  assign busy      = (state != IDLE);
  assign state_out = state;

  // Transaction sequencer: every output is set on the edge that enters the state it belongs to
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_DATA;
      owner      <= REQ_FETCH;
      lat_we     <= 1'b0;
      wait_cnt   <= '0;
      if_grant   <= 1'b0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      d_grant    <= 1'b0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
    end else begin
      if_grant <= 1'b0;
      d_grant  <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_grant <= winner;
            state      <= ACCESS;
            if (winner == REQ_DATA) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wr    <= d_we;
              lat_we    <= d_we;
              d_grant   <= 1'b1;
            end else begin
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              lat_we    <= 1'b0;
              if_grant  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (lat_we) begin
            d_valid <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= CNT_W'(READ_WAIT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (owner == REQ_DATA) begin
              d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset and long-latency sequences, and randomized traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int RW   = 2;
  localparam int NCYC = 400;
  localparam logic [31:0] AF = 32'h10;
  localparam logic [31:0] AD = 32'h40;
  localparam logic [31:0] WD = 32'h1234;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] Z  = 32'h0;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_ig;
    logic        e_iv;
    logic [31:0] e_ir;
    logic        e_dg;
    logic        e_dv;
    logic [31:0] e_dr;
    logic        e_wr;
    logic [31:0] e_wdata;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [1:0]  e_state;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        if_req, if_grant, if_valid, d_req, d_we, d_grant, d_valid, mem_wr, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state_out;

  logic        if_req4, if_grant4, if_valid4, d_req4, d_we4, d_grant4, d_valid4, mem_wr4, busy4;
  logic [31:0] if_addr4, if_rdata4, d_addr4, d_wdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic [1:0]  state_out4;

  logic [31:0] mem_arr  [64];
  logic [31:0] init_arr [64];
  logic [31:0] ref_mem  [64];
  logic        mem_init;

  int n_vec  = 0;
  int n_miss = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_WAIT(RW)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy), .state_out(state_out)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_WAIT(4)) dut4 (
    .clock(clock), .reset(reset),
    .if_req(if_req4), .if_addr(if_addr4), .if_grant(if_grant4), .if_valid(if_valid4), .if_rdata(if_rdata4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_grant(d_grant4), .d_valid(d_valid4), .d_rdata(d_rdata4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_wr(mem_wr4), .mem_rdata(mem_rdata4),
    .busy(busy4), .state_out(state_out4)
  );

  // Memory behind the main arbiter: combinational read, write on the clock edge
  assign mem_rdata = mem_arr[mem_addr[7:2]];
  always @(posedge clock) begin
    if (mem_init) mem_arr <= init_arr;
    else if (mem_wr) mem_arr[mem_addr[7:2]] <= mem_wdata;
  end

  // Memory behind the long-latency arbiter returns a pattern derived from the address
  assign mem_rdata4 = mem_addr4 ^ 32'hA5A50000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req  = v.if_req;
    if_addr = v.if_addr;
    d_req   = v.d_req;
    d_we    = v.d_we;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    chk({tag, ".if_grant"},  32'(if_grant),  32'(v.e_ig));
    chk({tag, ".if_valid"},  32'(if_valid),  32'(v.e_iv));
    chk({tag, ".if_rdata"},  if_rdata,       v.e_ir);
    chk({tag, ".d_grant"},   32'(d_grant),   32'(v.e_dg));
    chk({tag, ".d_valid"},   32'(d_valid),   32'(v.e_dv));
    chk({tag, ".d_rdata"},   d_rdata,        v.e_dr);
    chk({tag, ".mem_wr"},    32'(mem_wr),    32'(v.e_wr));
    chk({tag, ".mem_addr"},  mem_addr,       v.e_addr);
    chk({tag, ".busy"},      32'(busy),      32'(v.e_busy));
    chk({tag, ".state_out"}, 32'(state_out), 32'(v.e_state));
    if (v.e_wr) chk({tag, ".mem_wdata"}, mem_wdata, v.e_wdata);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  vec_t        tbl [25];
  vec_t        e;
  int          tg, tv;
  bit          act, in_txn, wn, mwe, last_m, fv, dv;
  bit          rq_f, rq_d, dwe;
  logic [31:0] maddr, mwd, fa, da, dwd, exp_addr, exp_ir, exp_dr;

  initial begin
    reset = 1'b1; mem_init = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req4 = 0; if_addr4 = 0; d_req4 = 0; d_we4 = 0; d_addr4 = 0; d_wdata4 = 0;
    for (int i = 0; i < 64; i++) init_arr[i] = 32'h0;
    init_arr[4] = DB;

    // ---------------- reset state ----------------
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    @(negedge clock);
    e = '{default: '0};
    checkOutput(e, "reset");
    chk("reset.mem_wdata", mem_wdata, Z);
    chk("reset.state_out4", 32'(state_out4), 32'd0);
    tick();
    reset = 1'b0;

    // ---------------- directed vector table ----------------
    tbl[0]  = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,Z,  1'b0,1'b0,Z,  1'b0,Z, Z,  1'b0,2'd0};
    tbl[1]  = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b1,1'b0,Z,  1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd1};
    tbl[2]  = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,Z,  1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd2};
    tbl[3]  = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,Z,  1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd2};
    tbl[4]  = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b1,DB, 1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd3};
    tbl[5]  = '{1'b0,AF,1'b1,1'b1,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AF, 1'b0,2'd0};
    tbl[6]  = '{1'b0,AF,1'b1,1'b1,AD,WD, 1'b0,1'b0,DB, 1'b1,1'b0,Z,  1'b1,WD,AD, 1'b1,2'd1};
    tbl[7]  = '{1'b0,AF,1'b1,1'b1,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b1,Z,  1'b0,Z, AD, 1'b1,2'd3};
    tbl[8]  = '{1'b0,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AD, 1'b0,2'd0};
    tbl[9]  = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AD, 1'b0,2'd0};
    tbl[10] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b1,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd1};
    tbl[11] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd2};
    tbl[12] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd2};
    tbl[13] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b1,DB, 1'b0,1'b0,Z,  1'b0,Z, AF, 1'b1,2'd3};
    tbl[14] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AF, 1'b0,2'd0};
    tbl[15] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b1,1'b0,Z,  1'b0,Z, AD, 1'b1,2'd1};
    tbl[16] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AD, 1'b1,2'd2};
    tbl[17] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,Z,  1'b0,Z, AD, 1'b1,2'd2};
    tbl[18] = '{1'b1,AF,1'b1,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b1,WD, 1'b0,Z, AD, 1'b1,2'd3};
    tbl[19] = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,WD, 1'b0,Z, AD, 1'b0,2'd0};
    tbl[20] = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b1,1'b0,DB, 1'b0,1'b0,WD, 1'b0,Z, AF, 1'b1,2'd1};
    tbl[21] = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,WD, 1'b0,Z, AF, 1'b1,2'd2};
    tbl[22] = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,WD, 1'b0,Z, AF, 1'b1,2'd2};
    tbl[23] = '{1'b1,AF,1'b0,1'b0,AD,WD, 1'b0,1'b1,DB, 1'b0,1'b0,WD, 1'b0,Z, AF, 1'b1,2'd3};
    tbl[24] = '{1'b0,AF,1'b0,1'b0,AD,WD, 1'b0,1'b0,DB, 1'b0,1'b0,WD, 1'b0,Z, AF, 1'b0,2'd0};
    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clock);
      checkOutput(tbl[i], $sformatf("tbl[%0d]", i));
      tick();
    end

    // ---------------- long read latency, req held one cycle past valid ----------------
    if_req4 = 1'b1;
    if_addr4 = 32'h20;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 14) if_req4 = 1'b0;
      @(negedge clock);
      chk($sformatf("rw4[%0d].if_grant", k), 32'(if_grant4), 32'((k == 1) || (k == 8)));
      chk($sformatf("rw4[%0d].if_valid", k), 32'(if_valid4), 32'((k == 6) || (k == 13)));
      if ((k == 6) || (k == 13)) chk($sformatf("rw4[%0d].if_rdata", k), if_rdata4, 32'hA5A50020);
      if (k == 7) chk("rw4[7].state_out", 32'(state_out4), 32'd0);
    end
    tick();

    // ---------------- reset during WAIT of a fetch read ----------------
    if_req = 1'b1; if_addr = AF; d_req = 1'b0; d_we = 1'b0;
    tick();
    tick();
    chk("rstwait.pre_state", 32'(state_out), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rstwait.state_out", 32'(state_out), 32'd0);
    chk("rstwait.busy", 32'(busy), 32'd0);
    chk("rstwait.mem_addr", mem_addr, Z);
    chk("rstwait.if_rdata", if_rdata, Z);
    chk("rstwait.d_rdata", d_rdata, Z);
    if_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rstwait.no_if_valid", 32'(if_valid), 32'd0);
      tick();
    end

    // ---------------- reset during ACCESS of a write ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h55;
    tick();
    chk("rstwr.mem_wr_before", 32'(mem_wr), 32'd1);
    chk("rstwr.d_grant", 32'(d_grant), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstwr.mem_wr_after", 32'(mem_wr), 32'd0);
    chk("rstwr.mem_addr", mem_addr, Z);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("rstwr.no_d_valid", 32'(d_valid), 32'd0);
      tick();
    end

    // ---------------- normal fetch after the abandoned transactions ----------------
    if_req = 1'b1; if_addr = AF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) if_req = 1'b0;
      @(negedge clock);
      chk($sformatf("post[%0d].if_grant", k), 32'(if_grant), 32'(k == 1));
      chk($sformatf("post[%0d].if_valid", k), 32'(if_valid), 32'(k == 4));
      chk($sformatf("post[%0d].busy", k), 32'(busy), 32'(k <= 4));
      if (k == 4) chk("post.if_rdata", if_rdata, DB);
    end
    tick();

    // ---------------- randomized traffic against the transaction model ----------------
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      init_arr[i] = $urandom;
      ref_mem[i]  = init_arr[i];
    end
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    tick();
    reset = 1'b0;
    act = 1'b0; last_m = 1'b1; tg = 0; tv = 0; wn = 1'b0; mwe = 1'b0; maddr = 0; mwd = 0;
    exp_addr = 0; exp_ir = 0; exp_dr = 0;
    rq_f = 1'b0; rq_d = 1'b0; dwe = 1'b0; fa = 0; da = 0; dwd = 0;
    for (int c = 0; c < NCYC; c++) begin
      if_req = rq_f; if_addr = fa; d_req = rq_d; d_we = dwe; d_addr = da; d_wdata = dwd;
      e = '{default: '0};
      in_txn = act && (c >= tg) && (c <= tv);
      if (in_txn) begin
        e.e_busy  = 1'b1;
        e.e_state = (c == tg) ? 2'd1 : ((c == tv) ? 2'd3 : 2'd2);
        e.e_ig    = (c == tg) && !wn;
        e.e_dg    = (c == tg) && wn;
        e.e_iv    = (c == tv) && !wn;
        e.e_dv    = (c == tv) && wn;
        e.e_wr    = (c == tg) && mwe;
        e.e_wdata = mwd;
        if (c == tg) begin
          exp_addr = maddr;
          if (mwe) ref_mem[maddr[7:2]] = mwd;
        end
        if ((c == tv) && !mwe) begin
          if (wn) exp_dr = ref_mem[maddr[7:2]];
          else    exp_ir = ref_mem[maddr[7:2]];
        end
      end
      e.e_addr = exp_addr;
      e.e_ir   = exp_ir;
      e.e_dr   = exp_dr;
      @(negedge clock);
      checkOutput(e, "rnd");

      fv = in_txn && (c == tv) && !wn;
      dv = in_txn && (c == tv) && wn;
      if (in_txn && (c == tv)) begin
        act = 1'b0;
      end else if (!in_txn && (rq_f || rq_d)) begin
        if (rq_f && rq_d) wn = ~last_m;
        else              wn = rq_d;
        mwe    = wn ? dwe : 1'b0;
        maddr  = wn ? da : fa;
        mwd    = dwd;
        tg     = c + 1;
        tv     = mwe ? (c + 2) : (c + 2 + RW);
        act    = 1'b1;
        last_m = wn;
      end

      if (fv) begin
        rq_f = ($urandom_range(0, 2) == 0);
        fa   = {24'h0, 3'b000, 3'($urandom_range(0, 7)), 2'b00};
      end else if (!rq_f && ($urandom_range(0, 2) == 0)) begin
        rq_f = 1'b1;
        fa   = {24'h0, 3'b000, 3'($urandom_range(0, 7)), 2'b00};
      end
      if (dv) begin
        rq_d = ($urandom_range(0, 2) == 0);
        da   = {24'h0, 3'b000, 3'($urandom_range(0, 7)), 2'b00};
        dwe  = 1'($urandom_range(0, 1));
        dwd  = $urandom;
      end else if (!rq_d && ($urandom_range(0, 2) == 0)) begin
        rq_d = 1'b1;
        da   = {24'h0, 3'b000, 3'($urandom_range(0, 7)), 2'b00};
        dwe  = 1'($urandom_range(0, 1));
        dwd  = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported instruction/data memory between the instruction-fetch requester and the load/store requester of the multicycle CPU. Accepts one request at a time, drives the memory address/write-enable, waits the fixed memory read latency, and returns read data with a one-cycle valid pulse. It replaces the hard-coded fetch wait states in the main control unit with a reusable, arbitrated handshake.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- READ_WAIT, 2, wait cycles between address issue and mem_rdata valid (≥1)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clock
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_grant  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request, level, held until d_valid
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_grant  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: read data valid / write complete
- d_rdata  out  DATA_W  data read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wr  out  1  memory MemReadWrite (1 = write)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in progress
- state_out  out  2  current state encoding, debug

## Operation
- States: IDLE(0), ACCESS(1), WAIT(2), RESP(3).
- IDLE: sample if_req/d_req. None → stay. One → latch its addr/we/wdata and id, go ACCESS. Both → round-robin: grant the requester not granted last; last_grant resets to DATA so the first tie after reset goes to fetch.
- ACCESS (1 cycle): grant pulse to winner; mem_addr/mem_wdata = latched values; mem_wr = latched we (fetch always 0). Write → RESP. Read → WAIT, counter = READ_WAIT−1.
- WAIT: mem_wr 0, mem_addr held; decrement counter; at 0 capture mem_rdata into winner's rdata register at the posedge, go RESP.
- RESP (1 cycle): winner's valid = 1, rdata stable; requests not sampled; → IDLE.
- Requester must drop req at the posedge ending its valid cycle; req still high in the next IDLE is a new request.
- rdata registers hold last captured value until next capture for that port; writes never change d_rdata.
- busy = state ≠ IDLE. Grant/valid of the non-winning port stay 0.
- Requests arriving in ACCESS/WAIT/RESP wait; no queueing beyond the level req.

## Timing
- All outputs registered. Reset (async, immediate): state IDLE, all grant/valid 0, mem_wr 0, mem_addr/mem_wdata/if_rdata/d_rdata 0, busy 0, state_out 0, last_grant DATA.
- Read: req high in cycle N → grant N+1 → valid N+2+READ_WAIT (N+4 at default). Write: grant N+1, mem_wr high N+1 only, valid N+2.
- Back-to-back throughput: one read per READ_WAIT+3 cycles, one write per 3 cycles.
- Reset mid-transaction: transaction abandoned, no valid pulse, mem_wr drops in the same cycle.
- Simultaneous req rise in the same IDLE cycle: exactly one grant; loser served next IDLE.

## Structure
- Package mem_arb_pkg: state enum {IDLE, ACCESS, WAIT, RESP} (2-bit), requester enum {REQ_FETCH, REQ_DATA}.
- Sub-module arb_rr2: two-request round-robin picker (req pair + last_grant in → winner out, combinational), reused later for register-file port sharing.

## Test plan
- Fetch read alone, if_addr=0x10, mem returns 0xDEADBEEF after 2 waits → if_grant at N+1, if_valid+if_rdata=0xDEADBEEF at N+4, busy high N+1..N+4.
- Data write d_addr=0x40, d_wdata=0x1234 → mem_wr=1 with mem_addr=0x40, mem_wdata=0x1234 only at N+1; d_valid at N+2; d_rdata unchanged.
- Both requests in same cycle after reset → fetch granted first, data granted in the IDLE after if_valid; repeat tie → data first.
- Reset asserted during WAIT → outputs to reset values immediately, no valid pulse, next request served normally.
- READ_WAIT=4 build, fetch read → if_valid at N+6; requester holding req one extra cycle after valid → second grant observed.
